ahb_accel_spi: RTL and testbench
================================

// Module: ahb_accel_spi
// PURPOSE
//  AHB-Lite slave at 0x5300_0000 (decoder slot S5) bridging the Cortex-M0 bus to the Nexys4 ADXL362
//  accelerometer over SPI. A CPU write launches one 3-byte SPI transaction: command, register address, data.
//  Read status and read-back data are exposed as memory-mapped registers.
//  Consumes the decoder's slave select; its HRDATA/HREADYOUT feed the slave read multiplexer.
// PARAMETERS
//  CLK_DIV  25  HCLK cycles per SCLK half-period (SCLK = HCLK/(2*CLK_DIV)); legal range 2..255
// PORTS
//  HCLK       in   1   bus clock; sole clock
//  HRESETn    in   1   asynchronous reset, active low
//  HSEL       in   1   slave select from address decoder
//  HADDR      in   32  bus address; only [3:2] used
//  HTRANS     in   2   transfer type; bit1=1 means NONSEQ/SEQ
//  HWRITE     in   1   1=write
//  HREADY     in   1   bus ready; qualifies address phase
//  HWDATA     in   32  write data (data phase)
//  HRDATA     out  32  read data (data phase)
//  HREADYOUT  out  1   always 1 (zero wait states)
//  SPI_SCLK   out  1   SPI clock, mode 0 (idle low)
//  SPI_CSn    out  1   chip select, active low
//  SPI_MOSI   out  1   serial data to accelerometer
//  SPI_MISO   in   1   serial data from accelerometer
// BEHAVIOUR
//  Reset: HRDATA=0, HREADYOUT=1, SPI_SCLK=0, SPI_CSn=1, SPI_MOSI=0; STATUS=0, RDATA=0, FSM=IDLE.
//  Bus: address phase valid when HSEL&HTRANS[1]&HREADY; HADDR[3:2] and HWRITE registered; write
//   completes in the data phase using HWDATA; HRDATA driven combinationally from the registered offset.
//  Register map (offset):
//   0x0 CMD (W): [7:0] data byte, [15:8] reg addr, [16] 1=read(cmd 0x0B), 0=write(cmd 0x0A). Reads 0.
//   0x4 STATUS (R): [0] BUSY, [1] DONE (sticky), [2] OVR (sticky). [31:3]=0. Writes ignored.
//   0x8 RDATA (R): [7:0] byte captured in the 3rd SPI byte; [31:8]=0. Reading clears DONE.
//   0xC reads 0; writes ignored.
//  CMD write when IDLE: load 24-bit shift reg {cmd,addr,data}; clear OVR; BUSY=1 next cycle.
//  CMD write when BUSY: ignored; OVR set.
//  FSM: IDLE -> SETUP (CSn=0, wait CLK_DIV cycles) -> SHIFT (24 SCLK periods)
//   -> HOLD (SCLK=0, wait CLK_DIV cycles) -> IDLE (CSn=1, DONE=1, BUSY=0).
//  SHIFT: MOSI presents MSB of shift reg while SCLK low. MISO sampled on each SCLK rising edge
//   into the shift LSB. Shift reg shifts on each SCLK falling edge. 5-bit bit counter runs 0..23;
//   after 24th rising edge, SCLK returns low and FSM enters HOLD.
//  RDATA updated with shift reg [7:0] on entry to IDLE; updated for write commands too (value don't-care).
//  Transaction length is 2*CLK_DIV*24 + 2*CLK_DIV HCLK cycles, +/-1 cycle, from CMD data phase to CSn high.
//  Simultaneous events: DONE set and RDATA read in same cycle -> DONE=1 (set wins). CMD write in the
//   cycle FSM returns to IDLE -> treated as BUSY (ignored, OVR=1).
//  HRESETn low mid-transfer: immediate abort; all outputs return to reset values (CSn high asynchronously).
// TESTING
//  Reset mid-stream: assert HRESETn mid-SHIFT -> SPI_CSn=1, SPI_SCLK=0 at once; STATUS reads 0x0 after release.
//  Write reg: CMD<=0x0000_2D02 -> MOSI bytes 0x0A,0x2D,0x02 MSB-first; 24 SCLK pulses; CSn low throughout;
//   STATUS=0x1 during, 0x2 after.
//  Read reg: CMD<=0x0001_0000, MISO model returns 0xAD in byte 3 -> MOSI 0x0B,0x00,0x00; RDATA=0x0000_00AD;
//   STATUS reads 0x0 after RDATA read.
//  Overrun: second CMD write while BUSY -> ignored (MOSI unchanged), STATUS=0x5 during, 0x6 after completion;
//   next accepted CMD clears OVR.
//  Timing: CLK_DIV=2 -> SCLK period 4 HCLK; CSn low-to-first-rise >=2 HCLK; last-fall-to-CSn-high >=2 HCLK.
//  Bus protocol: HSEL=1 with HTRANS=IDLE or HREADY=0 -> no register change; HREADYOUT=1 always;
//   reads of 0xC/0x0 return 0.

Source files
------------

// File: rtl/ahb_accel_spi.sv
// AHB-Lite slave that issues 3-byte SPI transactions (cmd, addr, data) to an ADXL362
// accelerometer. CMD/STATUS/RDATA are memory-mapped; zero wait states.
module ahb_accel_spi #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        SPI_SCLK,
    output logic        SPI_CSn,
    output logic        SPI_MOSI,
    input  logic        SPI_MISO
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic        sclk_q, sclk_d;
    logic        miso_q, miso_d;
    logic [23:0] shift_q, shift_d;
    logic        done_set;

    logic        dp_valid, dp_write;
    logic [1:0]  dp_addr;
    logic        busy, done, ovr;
    logic [7:0]  rdata;
    logic        cmd_wr, cmd_accept, rd_rdata;

    logic        unused_bits;
    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:17]};

    assign busy       = (state_q != ST_IDLE);
    assign cmd_wr     = dp_valid && dp_write && (dp_addr == 2'd0);
    assign cmd_accept = cmd_wr && !busy;
    assign rd_rdata   = dp_valid && !dp_write && (dp_addr == 2'd2);

    assign HREADYOUT = 1'b1;
    assign SPI_SCLK  = sclk_q;
    assign SPI_CSn   = (state_q == ST_IDLE);
    assign SPI_MOSI  = (state_q == ST_SETUP || state_q == ST_SHIFT) ? shift_q[23] : 1'b0;

    always_comb begin
        HRDATA = '0;
        if (dp_valid && !dp_write) begin
            case (dp_addr)
                2'd1:    HRDATA = {29'd0, ovr, done, busy};
                2'd2:    HRDATA = {24'd0, rdata};
                default: HRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            miso_q  <= 1'b0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            miso_q  <= miso_d;
            shift_q <= shift_d;
        end
    end

    // MISO is latched on the rising SCLK edge and enters the shift LSB on the
    // following falling edge, so the 24th fall leaves byte 3 in shift[7:0].
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        miso_d   = miso_q;
        shift_d  = shift_q;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                bit_d  = '0;
                sclk_d = 1'b0;
                if (cmd_accept) begin
                    shift_d = {(HWDATA[16] ? 8'h0B : 8'h0A), HWDATA[15:8], HWDATA[7:0]};
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        miso_d = SPI_MISO;
                    end else begin
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[22:0], miso_q};
                        if (bit_q == 5'd23) begin
                            bit_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            done     <= 1'b0;
            ovr      <= 1'b0;
            rdata    <= '0;
        end else begin
            dp_valid <= HSEL & HTRANS[1] & HREADY;
            dp_write <= HWRITE;
            dp_addr  <= HADDR[3:2];
            if (cmd_wr)
                ovr <= busy;
            if (done_set)
                done <= 1'b1;
            else if (rd_rdata)
                done <= 1'b0;
            if (done_set)
                rdata <= shift_q[7:0];
        end
    end

endmodule

// File: tb/tb_ahb_accel_spi.sv
// Scoreboard bench for ahb_accel_spi (CLK_DIV=2): bus reads and SPI MOSI bytes are
// checked by monitors against expectation queues filled by the directed stimulus.
module tb_ahb_accel_spi;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        SPI_SCLK, SPI_CSn, SPI_MOSI;
    logic        SPI_MISO = 1'b0;

    ahb_accel_spi #(.CLK_DIV(2)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .SPI_SCLK(SPI_SCLK),
        .SPI_CSn(SPI_CSn), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    rd_exp_t    exp_rd[$];
    logic [7:0] exp_mosi[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       rd_dp = 1'b0;
    logic [23:0] miso_word = '0;
    logic [23:0] miso_sr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    always @(posedge HCLK) cyc++;

    // Read monitor: one data-phase sample per bus read.
    always @(negedge HCLK) begin
        if (rd_dp) begin
            if (exp_rd.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = exp_rd.pop_front();
                chk(e.name, HRDATA, e.val);
                chk("hreadyout", {31'd0, HREADYOUT}, 32'd1);
            end
        end
    end

    // Accelerometer model: mode 0, next bit presented after each falling SCLK.
    always @(negedge SPI_CSn) begin
        miso_sr  = miso_word;
        SPI_MISO = miso_sr[23];
    end
    always @(negedge SPI_SCLK) begin
        if (!SPI_CSn) begin
            miso_sr  = {miso_sr[22:0], 1'b0};
            SPI_MISO = miso_sr[23];
        end
    end

    // SPI monitor.
    int         bitn = 0;
    logic [7:0] cur = '0;
    int         t_fall_cs = 0, t_first_rise = 0, t_last_fall = 0;
    logic       first_rise = 1'b0;

    always @(negedge SPI_CSn) begin
        bitn       = 0;
        t_fall_cs  = cyc;
        first_rise = 1'b1;
    end

    always @(posedge SPI_SCLK) begin
        chk("csn_low_at_rise", {31'd0, SPI_CSn}, 32'd0);
        if (first_rise) begin
            t_first_rise = cyc;
            first_rise   = 1'b0;
        end
        cur = {cur[6:0], SPI_MOSI};
        bitn++;
        if (bitn % 8 == 0) begin
            if (exp_mosi.size() == 0)
                chk("mosi_unexpected", {24'd0, cur}, 32'hFFFF_FFFF);
            else
                chk("mosi_byte", {24'd0, cur}, {24'd0, exp_mosi.pop_front()});
        end
    end

    always @(negedge SPI_SCLK) t_last_fall = cyc;

    always @(posedge SPI_CSn) begin
        if (!HRESETn) begin
            exp_mosi.delete();
        end else begin
            chk("sclk_pulses", bitn, 32'd24);
            chk("setup_ge2", {31'd0, (t_first_rise - t_fall_cs) >= 2}, 32'd1);
            chk("hold_ge2", {31'd0, (cyc - t_last_fall) >= 2}, 32'd1);
            chk("xfer_len_100pm1", {31'd0, ((cyc - t_fall_cs) >= 99) && ((cyc - t_fall_cs) <= 101)}, 32'd1);
        end
    end

    task automatic bus_xfer(input logic sel, input logic [1:0] trans, input logic rdy,
                            input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        HSEL = sel; HTRANS = trans; HREADY = rdy; HWRITE = wr; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1; HWRITE = 1'b0; HWDATA = wdata;
        rd_dp = sel & trans[1] & rdy & ~wr;
        @(posedge HCLK); #1;
        rd_dp = 1'b0;
    endtask

    task automatic wr_cmd(input logic [31:0] data);
        bus_xfer(1'b1, 2'b10, 1'b1, 1'b1, 32'h5300_0000, data);
    endtask

    task automatic rd_reg(input logic [31:0] addr, input string name, input logic [31:0] exp);
        rd_exp_t e;
        e.name = name;
        e.val  = exp;
        exp_rd.push_back(e);
        bus_xfer(1'b1, 2'b10, 1'b1, 1'b0, addr, 32'd0);
    endtask

    task automatic wait_csn_high();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge HCLK); #1;
            if (SPI_CSn) begin
                ok = 1'b1;
                break;
            end
        end
        chk("csn_done_in_time", {31'd0, ok}, 32'd1);
        repeat (3) @(posedge HCLK);
        #1;
    endtask

    initial begin
        // Reset values.
        #12;
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        chk("rst_sclk", {31'd0, SPI_SCLK}, 32'd0);
        chk("rst_csn", {31'd0, SPI_CSn}, 32'd1);
        chk("rst_mosi", {31'd0, SPI_MOSI}, 32'd0);
        @(negedge HCLK); HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rd_reg(32'h5300_0004, "status_after_reset", 32'h0);

        // Abort mid-SHIFT with reset.
        miso_word = 24'h123456;
        exp_mosi.push_back(8'h0A); exp_mosi.push_back(8'h2D); exp_mosi.push_back(8'h02);
        wr_cmd(32'h0000_2D02);
        repeat (20) @(posedge HCLK);
        #3 HRESETn = 1'b0;
        #1;
        chk("abort_csn", {31'd0, SPI_CSn}, 32'd1);
        chk("abort_sclk", {31'd0, SPI_SCLK}, 32'd0);
        chk("abort_mosi", {31'd0, SPI_MOSI}, 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        rd_reg(32'h5300_0004, "status_after_abort", 32'h0);

        // Write register transaction.
        exp_mosi.push_back(8'h0A); exp_mosi.push_back(8'h2D); exp_mosi.push_back(8'h02);
        wr_cmd(32'h0000_2D02);
        rd_reg(32'h5300_0004, "status_busy_wr", 32'h1);
        wait_csn_high();
        rd_reg(32'h5300_0004, "status_done_wr", 32'h2);

        // Read register transaction.
        miso_word = 24'h0000AD;
        exp_mosi.push_back(8'h0B); exp_mosi.push_back(8'h00); exp_mosi.push_back(8'h00);
        wr_cmd(32'h0001_0000);
        wait_csn_high();
        rd_reg(32'h5300_0008, "rdata_ad", 32'h0000_00AD);
        rd_reg(32'h5300_0004, "status_after_rdata", 32'h0);

        // Overrun: second command while busy is dropped.
        miso_word = 24'h000000;
        exp_mosi.push_back(8'h0A); exp_mosi.push_back(8'h33); exp_mosi.push_back(8'h55);
        wr_cmd(32'h0000_3355);
        wr_cmd(32'h0001_7777);
        rd_reg(32'h5300_0004, "status_ovr_busy", 32'h5);
        wait_csn_high();
        rd_reg(32'h5300_0004, "status_ovr_done", 32'h6);
        exp_mosi.push_back(8'h0A); exp_mosi.push_back(8'h11); exp_mosi.push_back(8'h22);
        wr_cmd(32'h0000_1122);
        rd_reg(32'h5300_0004, "status_ovr_cleared", 32'h3);
        wait_csn_high();
        rd_reg(32'h5300_0008, "rdata_clear_done", 32'h0000_0000);

        // Bus protocol: unqualified transfers change nothing.
        bus_xfer(1'b1, 2'b00, 1'b1, 1'b1, 32'h5300_0000, 32'h0000_4444);
        bus_xfer(1'b1, 2'b10, 1'b0, 1'b1, 32'h5300_0000, 32'h0000_4444);
        bus_xfer(1'b1, 2'b10, 1'b1, 1'b1, 32'h5300_0004, 32'h0000_0007);
        rd_reg(32'h5300_0004, "status_no_change", 32'h0);
        rd_reg(32'h5300_000C, "read_0xC", 32'h0);
        rd_reg(32'h5300_0000, "read_cmd", 32'h0);
        repeat (10) @(posedge HCLK);
        #1;
        chk("csn_idle_end", {31'd0, SPI_CSn}, 32'd1);
        chk("rd_queue_empty", exp_rd.size(), 32'd0);
        chk("mosi_queue_empty", exp_mosi.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
